// File: rtl/noc_resp_arb.sv
// noc_resp_arb: packet-granular arbiter driving the outbound NoC byte channel.
// Round-robin by default; define NOC_ARB_FIXED_PRIO_EN for lowest-index-wins priority.

module noc_resp_arb_lane (
  input  logic       gnt,
  input  logic       valid,
  input  logic       last,
  input  logic [7:0] data,
  output logic       ready,
  output logic       last_sel,
  output logic [7:0] data_sel
);
  assign ready    = gnt & valid;
  assign last_sel = last & ready;
  assign data_sel = data & {8{ready}};
endmodule

module noc_resp_arb #(
  parameter int NREQ   = 3,
  parameter int MAXLEN = 203
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   src_req,
  input  logic [8*NREQ-1:0] src_data,
  input  logic [NREQ-1:0]   src_valid,
  input  logic [NREQ-1:0]   src_last,
  output logic [NREQ-1:0]   src_ready,
  output logic [NREQ-1:0]   gnt,
  output logic              noc_from_dev_ctl,
  output logic [7:0]        noc_from_dev_data,
  output logic              err_len,
  output logic              err_gap
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

  state_t               state, state_nxt;
  logic [NREQ-1:0]      gnt_nxt, winner;
  logic [7:0]           cnt, cnt_nxt, data_nxt, acc_data;
  logic                 ctl_nxt, acc_last, set_len, set_gap, done;
  logic [NREQ-1:0][7:0] lane_data, lane_sel;
  logic [NREQ-1:0]      lane_last;

  assign lane_data = src_data;

  // src_ready depends only on the registered grant and src_valid
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_lane
      noc_resp_arb_lane u_lane (
        .gnt      (gnt[gi]),
        .valid    (src_valid[gi]),
        .last     (src_last[gi]),
        .data     (lane_data[gi]),
        .ready    (src_ready[gi]),
        .last_sel (lane_last[gi]),
        .data_sel (lane_sel[gi])
      );
    end
  endgenerate

  always_comb begin
    acc_data = '0;
    acc_last = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      acc_data = acc_data | lane_sel[i];
      acc_last = acc_last | lane_last[i];
    end
  end

`ifdef NOC_ARB_FIXED_PRIO_EN
  always_comb begin
    winner = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (src_req[i]) begin
        winner    = '0;
        winner[i] = 1'b1;
      end
    end
  end
`else
  logic [PW-1:0] ptr, gidx, idx;
  logic [PW:0]   sum;

  // Scan from farthest to nearest after ptr so the nearest requester wins.
  always_comb begin
    winner = '0;
    sum    = '0;
    idx    = '0;
    for (int k = NREQ; k >= 1; k--) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
      idx = sum[PW-1:0];
      if (src_req[idx]) begin
        winner      = '0;
        winner[idx] = 1'b1;
      end
    end
  end

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NREQ; i++)
      if (gnt[i]) gidx = PW'(i);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    ptr <= PW'(NREQ - 1);
    else if (done) ptr <= gidx;
  end
`endif

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    cnt_nxt   = cnt;
    ctl_nxt   = 1'b0;
    data_nxt  = '0;
    set_len   = 1'b0;
    set_gap   = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (|src_req) begin
          gnt_nxt   = winner;
          cnt_nxt   = '0;
          state_nxt = XFER;
        end
      end
      XFER: begin
        if (|src_ready) begin
          ctl_nxt  = (cnt == 8'd0);
          data_nxt = acc_data;
          cnt_nxt  = (cnt == 8'hff) ? cnt : cnt + 8'd1;
          if (acc_last) begin
            done = 1'b1;
          end else if (cnt == 8'(MAXLEN - 1)) begin
            done    = 1'b1;
            set_len = 1'b1;
          end
        end else begin
          set_gap = 1'b1;
        end
      end
      GAP:     state_nxt = IDLE;
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
    if (done) begin
      state_nxt = GAP;
      gnt_nxt   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      gnt               <= '0;
      cnt               <= '0;
      noc_from_dev_ctl  <= 1'b0;
      noc_from_dev_data <= '0;
      err_len           <= 1'b0;
      err_gap           <= 1'b0;
    end else begin
      state             <= state_nxt;
      gnt               <= gnt_nxt;
      cnt               <= cnt_nxt;
      noc_from_dev_ctl  <= ctl_nxt;
      noc_from_dev_data <= data_nxt;
      err_len           <= err_len | set_len;
      err_gap           <= err_gap | set_gap;
    end
  end
endmodule

// File: tb/tb_noc_resp_arb.sv
// tb_noc_resp_arb: randomized bench; a packet-level arbitration model fills a scoreboard
// that a separate monitor drains against the NoC output, grant and idle-cycle timing.
module tb_noc_resp_arb;
  localparam int NREQ   = 3;
  localparam int MAXLEN = 203;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [NREQ-1:0]   src_req, src_valid, src_last, src_ready, gnt;
  logic [8*NREQ-1:0] src_data;
  logic              noc_from_dev_ctl, err_len, err_gap;
  logic [7:0]        noc_from_dev_data;

  noc_resp_arb #(.NREQ(NREQ), .MAXLEN(MAXLEN)) dut (
    .clk               (clk),
    .reset             (reset),
    .src_req           (src_req),
    .src_data          (src_data),
    .src_valid         (src_valid),
    .src_last          (src_last),
    .src_ready         (src_ready),
    .gnt               (gnt),
    .noc_from_dev_ctl  (noc_from_dev_ctl),
    .noc_from_dev_data (noc_from_dev_data),
    .err_len           (err_len),
    .err_gap           (err_gap)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] d; bit last; int dly; } bt_t;
  typedef struct { bit ctl; logic [7:0] d; int pre; } exp_t;

  bt_t             drvq[NREQ][$];
  bt_t             mq[NREQ][$];
  bt_t             hold[$];
  exp_t            expq[$];
  int              grq[$];
  logic [NREQ-1:0] rdy;
  int              total = 0, bad = 0;
  int              mptr;
  bit              m_err_len, m_err_gap, mon_en;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic add_byte(input int s, input logic [7:0] d, input bit last, input int dly, input bit drv);
    bt_t b;
    b.d = d; b.last = last; b.dly = dly;
    mq[s].push_back(b);
    if (drv) drvq[s].push_back(b);
    else     hold.push_back(b);
  endtask

  task automatic add_rand_pkt(input int s, input int len, input int dly_pct, input bit drv);
    for (int k = 0; k < len; k++)
      add_byte(s, 8'($urandom_range(1, 255)), k == len - 1,
               (int'($urandom_range(0, 99)) < dly_pct) ? int'($urandom_range(1, 2)) : 0, drv);
  endtask

  // Reference: serve whole packets (chunks of at most MAXLEN bytes) in arbitration order;
  // each header follows 2 NOP cycles plus any valid-low cycles the source inserts.
  task automatic model_run();
    bit first, stop;
    int w, n, idx;
    bt_t b;
    first = 1'b1;
    while (1) begin
      w = -1;
`ifdef NOC_ARB_FIXED_PRIO_EN
      for (int k = NREQ - 1; k >= 0; k--) if (mq[k].size() > 0) w = k;
`else
      for (int k = NREQ; k >= 1; k--) begin
        idx = (mptr + k) % NREQ;
        if (mq[idx].size() > 0) w = idx;
      end
`endif
      if (w < 0) break;
      grq.push_back(w);
      n = 0; stop = 1'b0;
      while (!stop) begin
        b = mq[w].pop_front();
        if (b.dly > 0) m_err_gap = 1'b1;
        expq.push_back('{ctl: (n == 0), d: b.d,
                         pre: (n == 0) ? (first ? -1 : 2 + b.dly) : b.dly});
        n++;
        if (b.last) stop = 1'b1;
        else if (n == MAXLEN) begin stop = 1'b1; m_err_len = 1'b1; end
      end
      mptr  = w;
      first = 1'b0;
    end
  endtask

  function automatic int drv_pending();
    int s = 0;
    for (int i = 0; i < NREQ; i++) s += drvq[i].size();
    return s;
  endfunction

  task automatic drain(input string nm);
    int c = 0;
    while ((expq.size() != 0 || grq.size() != 0 || drv_pending() != 0) && c < 3000) begin
      @(negedge clk); c++;
    end
    if (c >= 3000) begin
      total++; bad++;
      $display("FAIL %s timeout: exp_left=%0d grant_left=%0d", nm, expq.size(), grq.size());
      expq.delete(); grq.delete();
      for (int i = 0; i < NREQ; i++) drvq[i].delete();
    end
    repeat (4) @(negedge clk);
    chk({nm, "_err_len"}, err_len, m_err_len);
    chk({nm, "_err_gap"}, err_gap, m_err_gap);
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_gnt"}, gnt, 0);
    chk({nm, "_ready"}, src_ready, 0);
    chk({nm, "_ctl"}, noc_from_dev_ctl, 0);
    chk({nm, "_data"}, noc_from_dev_data, 0);
    chk({nm, "_err_len"}, err_len, 0);
    chk({nm, "_err_gap"}, err_gap, 0);
  endtask

  // Source drivers: advance on accepts seen last cycle, insert valid-low cycles only while granted.
  initial begin
    bt_t t;
    src_req = '0; src_valid = '0; src_last = '0; src_data = '0; rdy = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (rdy[i] && drvq[i].size() > 0) void'(drvq[i].pop_front());
        if (drvq[i].size() > 0) begin
          t = drvq[i][0];
          src_req[i] = 1'b1;
          src_data[8*i +: 8] = t.d;
          src_last[i] = t.last;
          if (gnt[i] && t.dly > 0) begin
            src_valid[i] = 1'b0;
            t.dly--;
            drvq[i][0] = t;
          end else begin
            src_valid[i] = 1'b1;
          end
        end else begin
          src_req[i] = 1'b0; src_valid[i] = 1'b0; src_last[i] = 1'b0; src_data[8*i +: 8] = '0;
        end
      end
      #1 rdy = src_ready;
    end
  end

  // Monitor: grants and NoC bytes against the scoreboard.
  initial begin
    int zeros, gexp;
    bit prev_g;
    logic [NREQ-1:0] cur_g;
    exp_t e;
    zeros = 0; prev_g = 1'b0; cur_g = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (gnt != '0) begin
          if (!prev_g) begin
            if (grq.size() == 0) begin
              total++; bad++;
              $display("FAIL unexpected_grant: got %0h want none", gnt);
            end else begin
              gexp = grq.pop_front();
              chk("grant", gnt, 32'(1) << gexp);
            end
            cur_g = gnt;
          end else begin
            chk("grant_hold", gnt, cur_g);
          end
        end
        prev_g = |gnt;
        if (noc_from_dev_ctl || noc_from_dev_data != 8'h00) begin
          if (expq.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_byte: got ctl=%0d data=%0h want none", noc_from_dev_ctl, noc_from_dev_data);
          end else begin
            e = expq.pop_front();
            chk("ctl", noc_from_dev_ctl, e.ctl);
            chk("data", noc_from_dev_data, e.d);
            if (e.pre >= 0) chk("nop_cycles", zeros, e.pre);
          end
          zeros = 0;
        end else begin
          zeros++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    mon_en = 1'b0; mptr = NREQ - 1; m_err_len = 1'b0; m_err_gap = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outs("reset");
    #2 reset = 1'b1;
    mon_en = 1'b1;

    // single packet from source 1
    @(posedge clk); #2;
    add_byte(1, 8'h04, 0, 0, 1); add_byte(1, 8'h02, 0, 0, 1);
    add_byte(1, 8'h05, 0, 0, 1); add_byte(1, 8'h03, 1, 0, 1);
    model_run();
    drain("single");

    // late request: source 1 arrives while source 0 is mid-packet
    @(posedge clk); #2;
    hold.delete();
    add_rand_pkt(0, 8, 0, 1);
    add_rand_pkt(1, 3, 0, 0);
    model_run();
    c = 0;
    while (drvq[0].size() > 5 && c < 200) begin @(negedge clk); c++; end
    #2;
    foreach (hold[k]) drvq[1].push_back(hold[k]);
    drain("late");

    // round-robin fairness, two 2-byte packets per source
    @(posedge clk); #2;
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < NREQ; s++) add_rand_pkt(s, 2, 0, 1);
    model_run();
    drain("rr");

    // source 2 drops valid for 2 cycles after its header
    @(posedge clk); #2;
    add_byte(2, 8'h11, 0, 0, 1); add_byte(2, 8'h22, 0, 2, 1);
    add_byte(2, 8'h33, 0, 0, 1); add_byte(2, 8'h44, 1, 0, 1);
    model_run();
    drain("vgap");

    // length limit: 210-byte packet truncated at MAXLEN, source 1 served next
    @(posedge clk); #2;
    add_rand_pkt(0, 210, 0, 1);
    add_rand_pkt(1, 3, 0, 1);
    model_run();
    drain("maxlen");

    // asynchronous reset during byte 3
    @(posedge clk); #2;
    add_rand_pkt(0, 6, 0, 1);
    model_run();
    c = 0;
    while (drvq[0].size() > 4 && c < 200) begin @(negedge clk); c++; end
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    chk_reset_outs("midreset");
    for (int i = 0; i < NREQ; i++) drvq[i].delete();
    expq.delete(); grq.delete(); rdy = '0;
    mptr = NREQ - 1; m_err_len = 1'b0; m_err_gap = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    @(posedge clk); #2;
    add_rand_pkt(2, 3, 0, 1);
    add_rand_pkt(0, 3, 0, 1);
    model_run();
    drain("post_reset");

    // randomized traffic
    for (int r = 0; r < 25; r++) begin
      @(posedge clk); #2;
      for (int s = 0; s < NREQ; s++)
        if ($urandom_range(0, 1) == 1)
          for (int p = 0; p < int'($urandom_range(1, 3)); p++)
            add_rand_pkt(s, int'($urandom_range(1, 6)), 20, 1);
      model_run();
      drain("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
